// File: rtl/ar_srl_fifo_lvl_if.sv
// ar_srl_fifo_lvl_if
// Handshake/status bundle for the SRL-based FIFO with level flags.
//   CLR      : synchronous flush request (active-high)
//   ENQ/D_IN : enqueue request and write data
//   DEQ      : dequeue request (consumes D_OUT)
//   D_OUT    : head word
//   FULL_N   : low when the FIFO holds CAP words
//   EMPTY_N  : high when D_OUT is valid
//   AFULL_N  : low when COUNT >= almost-full level
//   AEMPTY_N : low when COUNT <= almost-empty level
//   COUNT    : words held (shift register plus output register)
//   OVF/UNF  : sticky overflow / underflow indicators
// master = producer/consumer side, slave = FIFO side.
interface ar_srl_fifo_lvl_if #(
    parameter int WIDTH   = 32,
    parameter int L2DEPTH = 5
);
    logic               CLR;
    logic               ENQ;
    logic [WIDTH-1:0]   D_IN;
    logic               DEQ;
    logic [WIDTH-1:0]   D_OUT;
    logic               FULL_N;
    logic               EMPTY_N;
    logic               AFULL_N;
    logic               AEMPTY_N;
    logic [L2DEPTH:0]   COUNT;
    logic               OVF;
    logic               UNF;

    modport master (
        output CLR, ENQ, D_IN, DEQ,
        input  D_OUT, FULL_N, EMPTY_N, AFULL_N, AEMPTY_N, COUNT, OVF, UNF
    );

    modport slave (
        input  CLR, ENQ, D_IN, DEQ,
        output D_OUT, FULL_N, EMPTY_N, AFULL_N, AEMPTY_N, COUNT, OVF, UNF
    );
endinterface

// File: rtl/ar_srl_fifo_lvl.sv
// ar_srl_fifo_lvl
// FIFO built from a shift register (SRL-inferable, no reset on the data
// array) followed by an output register that drives D_OUT directly.
// Capacity is 2**L2DEPTH + 1 words.
// Ports:
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   bus   : ar_srl_fifo_lvl_if slave modport (see interface header)
module ar_srl_fifo_lvl #(
    parameter int WIDTH      = 32,
    parameter int L2DEPTH    = 5,
    parameter int AFULL_LVL  = (2 ** L2DEPTH) - 3,
    parameter int AEMPTY_LVL = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    ar_srl_fifo_lvl_if.slave   bus
);
    localparam int DEPTH = 2 ** L2DEPTH;
    localparam int CW    = L2DEPTH + 1;
    localparam logic [CW-1:0] CAP_C    = CW'(DEPTH + 1);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [WIDTH-1:0]   d_out_r;
    logic [CW-1:0]      rd_ptr_r;   // number of words in the shift register
    logic [CW-1:0]      cnt_r;
    logic               out_valid_r;
    logic               ovf_r;
    logic               unf_r;

    logic               full_n_s;
    logic               enq_acc_s;
    logic               deq_acc_s;
    logic               xfer_s;
    logic [L2DEPTH-1:0] rd_idx_s;
    logic [CW-1:0]      rd_ptr_nxt_s;
    logic [CW-1:0]      cnt_nxt_s;
    logic               out_valid_nxt_s;

    assign full_n_s  = (cnt_r != CAP_C);
    assign enq_acc_s = bus.ENQ & full_n_s;
    assign deq_acc_s = bus.DEQ & out_valid_r;

    // Transfer and next-state decode for pointer, count and head-valid.
    always_comb begin
        xfer_s          = 1'b0;
        rd_idx_s        = '0;
        rd_ptr_nxt_s    = rd_ptr_r;
        cnt_nxt_s       = cnt_r;
        out_valid_nxt_s = out_valid_r;

        // Oldest shift-register word sits just below the pointer.
        rd_idx_s = L2DEPTH'(rd_ptr_r - CW'(1));

        if ((rd_ptr_r != CW'(0)) && (!out_valid_r || deq_acc_s)) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end

        if (enq_acc_s && !xfer_s) begin
            rd_ptr_nxt_s = rd_ptr_r + CW'(1);
        end else if (xfer_s && !enq_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r - CW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({enq_acc_s, deq_acc_s})
            2'b10:   cnt_nxt_s = cnt_r + CW'(1);
            2'b01:   cnt_nxt_s = cnt_r - CW'(1);
            default: cnt_nxt_s = cnt_r;
        endcase

        if (xfer_s) begin
            out_valid_nxt_s = 1'b1;
        end else if (deq_acc_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Shift-register storage; deliberately unreset so it maps onto SRLs.
    always_ff @(posedge CLK) begin
        if (RST_N && !bus.CLR && enq_acc_s) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_r[i] <= mem_r[i-1];
            end
            mem_r[0] <= bus.D_IN;
        end
    end

    // Output data register; contents are don't-care while out_valid_r is low.
    always_ff @(posedge CLK) begin
        if (RST_N && !bus.CLR && xfer_s) begin
            d_out_r <= mem_r[rd_idx_s];
        end
    end

    // Control state with synchronous reset and flush.
    always_ff @(posedge CLK) begin
        if (!RST_N || bus.CLR) begin
            rd_ptr_r    <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            ovf_r       <= ovf_r | (bus.ENQ & ~full_n_s);
            unf_r       <= unf_r | (bus.DEQ & ~out_valid_r);
        end
    end

    assign bus.D_OUT    = d_out_r;
    assign bus.COUNT    = cnt_r;
    assign bus.FULL_N   = full_n_s;
    assign bus.EMPTY_N  = out_valid_r;
    assign bus.AFULL_N  = (cnt_r < AFULL_C);
    assign bus.AEMPTY_N = (cnt_r > AEMPTY_C);
    assign bus.OVF      = ovf_r;
    assign bus.UNF      = unf_r;
endmodule

// File: doc/ar_srl_fifo_lvl.md
AR_SRL_FIFO_LVL -- requirements
Module: ar_srl_fifo_lvl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data word width in bits (1..1024).
REQ-002 SHALL provide parameter L2DEPTH, default 5, log2 of shift-register storage depth; DEPTH = 2**L2DEPTH; total capacity CAP = DEPTH+1 (shift register plus output register).
REQ-003 SHALL provide parameter AFULL_LVL, default DEPTH-3, almost-full threshold in words (1..CAP).
REQ-004 SHALL provide parameter AEMPTY_LVL, default 2, almost-empty threshold in words (0..CAP-1).
REQ-005 CLK  input  1  clock; all state changes on rising edge.
REQ-006 RST_N  input  1  reset, synchronous, active-low.
REQ-007 CLR  input  1  synchronous flush, active-high.
REQ-008 ENQ  input  1  enqueue request; D_IN sampled on the same edge.
REQ-009 D_IN  input  WIDTH  write data.
REQ-010 DEQ  input  1  dequeue request; consumes the current D_OUT.
REQ-011 D_OUT  output  WIDTH  head word, driven directly from the output register.
REQ-012 FULL_N  output  1  high = ENQ will be accepted.
REQ-013 EMPTY_N  output  1  high = D_OUT valid, DEQ will be accepted.
REQ-014 AFULL_N  output  1  low when COUNT >= AFULL_LVL.
REQ-015 AEMPTY_N  output  1  low when COUNT <= AEMPTY_LVL.
REQ-016 COUNT  output  L2DEPTH+1  words held (shift register plus output register).
REQ-017 OVF  output  1  sticky; set when ENQ is sampled with FULL_N low.
REQ-018 UNF  output  1  sticky; set when DEQ is sampled with EMPTY_N low.

Function
REQ-019 Storage SHALL be a shift register: on an accepted ENQ all entries shift up one and D_IN enters entry 0, with no reset on the data array, so synthesis infers SRLs.
REQ-020 A read pointer SHALL index the oldest shift-register entry; the pointer increments on accepted ENQ without transfer, decrements on transfer without accepted ENQ, and holds otherwise.
REQ-021 Transfer to the output register SHALL occur when the shift register is non-empty AND (the output register is empty OR an accepted DEQ occurs this cycle).
REQ-022 Accepted ENQ = ENQ & FULL_N; accepted DEQ = DEQ & EMPTY_N; rejected requests SHALL NOT change data, pointer, COUNT or flags other than OVF/UNF.
REQ-023 Latency: an ENQ accepted into an empty block SHALL raise EMPTY_N with D_OUT valid after exactly 2 rising edges.
REQ-024 Throughput: with continuous ENQ and DEQ in steady state (COUNT >= 2), one word in and one word out SHALL occur per cycle.
REQ-025 COUNT SHALL be registered: +1 on accepted ENQ only, -1 on accepted DEQ only, unchanged when both or neither; range 0..CAP, never wraps.
REQ-026 FULL_N SHALL be low iff COUNT == CAP; when full, simultaneous ENQ and DEQ SHALL reject the ENQ (set OVF) and accept the DEQ.
REQ-027 When EMPTY_N is low, simultaneous ENQ and DEQ SHALL accept the ENQ and reject the DEQ (set UNF).
REQ-028 AFULL_N and AEMPTY_N SHALL be combinational decodes of registered COUNT only.
REQ-029 OVF and UNF SHALL remain set until reset or CLR.
REQ-030 Order SHALL be strictly FIFO; no word is duplicated or lost across pointer wrap between 0 and DEPTH.

Reset
REQ-031 On RST_N low or CLR high at a rising edge: pointer=0, COUNT=0, EMPTY_N=0, FULL_N=1, AFULL_N=1, AEMPTY_N=0, OVF=0, UNF=0; D_OUT and storage contents are undefined; ENQ/DEQ on that edge are ignored.
REQ-032 Reset or CLR asserted mid-stream SHALL discard all held words; the first accepted ENQ afterwards SHALL emerge per REQ-023.

Verification
REQ-033 Reset, then ENQ 0xA5 for one cycle -> EMPTY_N=1 and D_OUT=0xA5 two edges later, COUNT=1, AEMPTY_N=0.
REQ-034 Defaults; ENQ 33 words 0..32 with no DEQ -> FULL_N=0 and COUNT=33; 34th ENQ -> OVF=1 and COUNT stays 33; drain yields 0..32 in order, then EMPTY_N=0.
REQ-035 COUNT=33, ENQ and DEQ together -> DEQ accepted, ENQ rejected, COUNT=32, OVF=1.
REQ-036 Empty, ENQ and DEQ together -> UNF=1, COUNT=1 the next cycle, word emerges per REQ-023.
REQ-037 Fill to 10, then 1000 cycles of random ENQ/DEQ against a scoreboard -> data order exact; AFULL_N low exactly when COUNT>=29; AEMPTY_N low exactly when COUNT<=2.
REQ-038 COUNT=20, CLR pulse for 1 cycle -> COUNT=0, EMPTY_N=0, FULL_N=1, OVF=0, UNF=0 on the next cycle.
